// File: rtl/planificador_pkg.sv
// planificador_pkg: shared widths and types for the sensor scheduler.
// Temperature samples are 11-bit signed, monitor state is 2 bits wide.
package planificador_pkg;
  localparam int TEMP_W = 11;
  localparam int EST_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    INACTIVO,
    SOLICITAR,
    ASENTAR,
    CAPTURAR
  } estado_plan_t;

  typedef logic signed [TEMP_W-1:0] temp_t;
endpackage

// File: rtl/planificador_sensores_temporizador_espera.sv
// temporizador_espera: up-counter cleared on demand, flags when it hits limite.
// Shared by the handshake timeout and the monitor settle wait.
import planificador_pkg::*;

module temporizador_espera (
  input  logic             clk,
  input  logic             arst,
  input  logic             limpiar,
  input  logic [CNT_W-1:0] limite,
  output logic             fin
);

  logic [CNT_W-1:0] cuenta;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cuenta <= '0;
    end else if (limpiar) begin
      cuenta <= '0;
    end else begin
      cuenta <= cuenta + 1'b1;
    end
  end

  assign fin = (cuenta == limite);

endmodule

// File: rtl/planificador_sensores.sv
// planificador_sensores: round-robin scheduler multiplexing sensors onto one monitor.
// Optional macro CONTADOR_ALERTAS_EN adds saturating per-channel alert counters.
import planificador_pkg::*;

module planificador_sensores #(
  parameter int N_SENSORES = 4,
  parameter int ESPERA     = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          habilitar,
  input  logic [N_SENSORES-1:0]         sens_valid,
  input  logic [TEMP_W*N_SENSORES-1:0]  sens_temp,
  output logic [N_SENSORES-1:0]         sens_ready,
  output temp_t                         mon_temp,
  input  logic                          mon_alerta,
  input  logic [EST_W-1:0]              mon_estado,
  output logic [$clog2(N_SENSORES)-1:0] canal_actual,
  output logic [N_SENSORES-1:0]         alerta_canal,
  output logic [EST_W*N_SENSORES-1:0]   estado_canal,
  output logic [N_SENSORES-1:0]         falla_canal,
  output logic                          alerta_global,
  output logic                          ciclo_completo
`ifdef CONTADOR_ALERTAS_EN
  ,
  output logic [3*N_SENSORES-1:0]       cnt_alertas
`endif
);

  localparam int PTR_W = $clog2(N_SENSORES);
  localparam logic [PTR_W-1:0] ULTIMO  = PTR_W'(N_SENSORES - 1);
  localparam logic [CNT_W-1:0] LIM_ESP = CNT_W'(ESPERA - 1);
  localparam logic [CNT_W-1:0] LIM_TO  = CNT_W'(TIMEOUT - 1);

  estado_plan_t     estado, estado_sig;
  logic [PTR_W-1:0] ptr;
  logic             transferir;
  logic             timeout;
  logic             capturar;
  logic             avanzar;
  logic             limpiar;
  logic             fin;
  logic [CNT_W-1:0] limite;

  assign canal_actual = ptr;
  assign avanzar      = timeout | capturar;
  assign limite       = (estado == ASENTAR) ? LIM_ESP : LIM_TO;

  temporizador_espera u_temporizador (
    .clk     (clk),
    .arst    (arst),
    .limpiar (limpiar),
    .limite  (limite),
    .fin     (fin)
  );

  always_comb begin
    estado_sig = estado;
    transferir = 1'b0;
    timeout    = 1'b0;
    capturar   = 1'b0;
    limpiar    = 1'b1;
    sens_ready = '0;
    unique case (estado)
      INACTIVO: begin
        if (habilitar) estado_sig = SOLICITAR;
      end
      SOLICITAR: begin
        sens_ready[ptr] = 1'b1;
        if (sens_valid[ptr]) begin
          transferir = 1'b1;
          estado_sig = ASENTAR;
        end else if (fin) begin
          timeout    = 1'b1;
          estado_sig = habilitar ? SOLICITAR : INACTIVO;
        end else begin
          limpiar = 1'b0;
        end
      end
      ASENTAR: begin
        if (fin) estado_sig = CAPTURAR;
        else     limpiar    = 1'b0;
      end
      CAPTURAR: begin
        capturar   = 1'b1;
        estado_sig = habilitar ? SOLICITAR : INACTIVO;
      end
      default: estado_sig = INACTIVO;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      estado         <= INACTIVO;
      ptr            <= '0;
      mon_temp       <= '0;
      alerta_canal   <= '0;
      estado_canal   <= '0;
      falla_canal    <= '0;
      alerta_global  <= 1'b0;
      ciclo_completo <= 1'b0;
    end else begin
      estado <= estado_sig;
      if (transferir) begin
        mon_temp <= sens_temp[int'(ptr)*TEMP_W +: TEMP_W];
      end
      if (avanzar) begin
        ptr <= (ptr == ULTIMO) ? '0 : ptr + 1'b1;
      end
      if (timeout) begin
        falla_canal[ptr] <= 1'b1;
      end
      if (capturar) begin
        alerta_canal[ptr]                     <= mon_alerta;
        estado_canal[int'(ptr)*EST_W +: EST_W] <= mon_estado;
        falla_canal[ptr]                      <= 1'b0;
      end
      alerta_global  <= (|alerta_canal) | (|falla_canal);
      ciclo_completo <= avanzar && (ptr == ULTIMO);
    end
  end

`ifdef CONTADOR_ALERTAS_EN
  logic [2:0] cnt_sel;

  assign cnt_sel = cnt_alertas[int'(ptr)*3 +: 3];

  // Saturates at 7; any clean capture restarts the run.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_alertas <= '0;
    end else if (capturar) begin
      if (!mon_alerta) begin
        cnt_alertas[int'(ptr)*3 +: 3] <= 3'd0;
      end else if (cnt_sel != 3'd7) begin
        cnt_alertas[int'(ptr)*3 +: 3] <= cnt_sel + 3'd1;
      end
    end
  end
`endif

endmodule
